// File: rtl/pir_occupancy_ctrl.sv
// PIR occupancy controller: warm-up lockout, LED blink while occupied,
// retriggerable hold after motion drops, and a saturating motion event counter.
// All outputs are registered; motion_in acts on the next rising edge of clk.
module pir_occupancy_ctrl #(
  parameter int unsigned WARMUP_CYC = 32000000,
  parameter int unsigned BLINK_HALF = 16000000,
  parameter int unsigned HOLD_CYC   = 320000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motion_in,
  output logic       led,
  output logic       occupied,
  output logic       ready,
  output logic       event_pulse,
  output logic [7:0] event_count
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [31:0] WARM_LAST  = 32'(WARMUP_CYC - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);

  state_t      state;
  logic [31:0] timer;
  logic [31:0] blink_cnt;

  // Single FSM: state, timers and every output are updated together on each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WARMUP;
      timer       <= '0;
      blink_cnt   <= '0;
      led         <= 1'b0;
      occupied    <= 1'b0;
      ready       <= 1'b0;
      event_pulse <= 1'b0;
      event_count <= '0;
    end else begin
      event_pulse <= 1'b0;

      // Blink runs through both occupied states so the phase survives retriggers.
      if (state == ACTIVE || state == HOLD) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          led       <= ~led;
        end else begin
          blink_cnt <= blink_cnt + 32'd1;
        end
      end

      case (state)
        WARMUP: begin
          if (timer == WARM_LAST) begin
            state <= IDLE;
            ready <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        IDLE: begin
          led      <= 1'b0;
          occupied <= 1'b0;
          if (motion_in) begin
            state       <= ACTIVE;
            led         <= 1'b1;
            occupied    <= 1'b1;
            blink_cnt   <= '0;
            event_pulse <= 1'b1;
            if (event_count != 8'hFF) begin
              event_count <= event_count + 8'd1;
            end
          end
        end

        ACTIVE: begin
          if (!motion_in) begin
            state <= HOLD;
            timer <= '0;
          end
        end

        HOLD: begin
          // Motion beats a simultaneous hold expiry.
          if (motion_in) begin
            state <= ACTIVE;
          end else if (timer == HOLD_LAST) begin
            state    <= IDLE;
            led      <= 1'b0;
            occupied <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        default: begin
          state <= WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pir_occupancy_ctrl.sv
// Bench for pir_occupancy_ctrl: directed scenarios with literal checks plus an
// every-cycle comparison against an event-level behavioural model.
module tb_pir_occupancy_ctrl;

  localparam int W  = 8;
  localparam int BH = 4;
  localparam int H  = 10;

  logic       clk;
  logic       rst;
  logic       motion_in;
  logic       led;
  logic       occupied;
  logic       ready;
  logic       event_pulse;
  logic [7:0] event_count;

  int n_cmp = 0;
  int n_bad = 0;

  pir_occupancy_ctrl #(
    .WARMUP_CYC(W),
    .BLINK_HALF(BH),
    .HOLD_CYC  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .motion_in  (motion_in),
    .led        (led),
    .occupied   (occupied),
    .ready      (ready),
    .event_pulse(event_pulse),
    .event_count(event_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state, described in terms of elapsed edges rather than FSM states:
  // warm = edges since reset, k = edges since the event began,
  // low = consecutive low samples while occupied.
  int   m_warm, m_k, m_low, m_cnt;
  logic m_ready, m_occ, m_pulse, m_led;

  initial begin
    m_warm = 0; m_k = 0; m_low = 0; m_cnt = 0;
    m_ready = 0; m_occ = 0; m_pulse = 0; m_led = 0;
    forever begin
      @(posedge clk or posedge rst);
      m_pulse = 1'b0;
      if (rst) begin
        m_warm = 0; m_k = 0; m_low = 0; m_cnt = 0;
        m_ready = 0; m_occ = 0;
      end else if (!m_ready) begin
        m_warm++;
        if (m_warm == W) m_ready = 1'b1;
      end else if (!m_occ) begin
        if (motion_in) begin
          m_occ   = 1'b1;
          m_k     = 0;
          m_low   = 0;
          m_pulse = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        m_k++;
        if (motion_in) begin
          m_low = 0;
        end else begin
          m_low++;
          if (m_low == H + 1) m_occ = 1'b0;
        end
      end
      m_led = m_occ && (((m_k / BH) % 2) == 0);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    n_cmp++;
    if (led !== m_led || occupied !== m_occ || ready !== m_ready ||
        event_pulse !== m_pulse || event_count !== m_cnt[7:0]) begin
      n_bad++;
      $display("FAIL model t=%0t got led=%b occ=%b rdy=%b pls=%b cnt=%0d want led=%b occ=%b rdy=%b pls=%b cnt=%0d",
               $time, led, occupied, ready, event_pulse, event_count,
               m_led, m_occ, m_ready, m_pulse, m_cnt);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle so inputs change away from the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    motion_in = 1'b1;
    step(2);
    rst = 1'b0;

    // Warm-up lockout with motion held high from reset.
    step(7);
    check("warm_ready_e7", int'(ready), 0);
    check("warm_led_e7", int'(led), 0);
    check("warm_cnt_e7", int'(event_count), 0);
    step(1);
    check("warm_ready_e8", int'(ready), 1);
    check("warm_occ_e8", int'(occupied), 0);
    step(1);
    check("start_occ", int'(occupied), 1);
    check("start_pulse", int'(event_pulse), 1);
    check("start_led", int'(led), 1);
    check("start_cnt", int'(event_count), 1);

    // Blink and hold: 20 high cycles in total, then let the hold expire.
    step(3);
    check("blink_led_k3", int'(led), 1);
    step(1);
    check("blink_led_k4", int'(led), 0);
    step(4);
    check("blink_led_k8", int'(led), 1);
    step(11);
    motion_in = 1'b0;
    step(1);
    check("hold_occ_n", int'(occupied), 1);
    step(9);
    check("hold_occ_n9", int'(occupied), 1);
    step(1);
    check("hold_occ_n10", int'(occupied), 0);
    check("hold_led_n10", int'(led), 0);
    check("hold_cnt", int'(event_count), 1);
    step(3);

    // Retrigger during hold: no new event.
    motion_in = 1'b1;
    step(2);
    check("retrig_cnt0", int'(event_count), 2);
    motion_in = 1'b0;
    step(6);
    motion_in = 1'b1;
    step(1);
    check("retrig_pulse", int'(event_pulse), 0);
    check("retrig_cnt", int'(event_count), 2);
    check("retrig_occ", int'(occupied), 1);
    step(5);

    // Motion arrives on the exact expiry cycle.
    motion_in = 1'b0;
    step(10);
    check("coll_occ_pre", int'(occupied), 1);
    motion_in = 1'b1;
    step(1);
    check("coll_occ", int'(occupied), 1);
    check("coll_pulse", int'(event_pulse), 0);
    motion_in = 1'b0;
    step(12);
    check("coll_occ_end", int'(occupied), 0);
    check("coll_cnt", int'(event_count), 2);

    // Saturation: 300 isolated events each followed by full expiry.
    pulses = 0;
    for (int e = 0; e < 300; e++) begin
      motion_in = 1'b1;
      step(1);
      if (event_pulse) pulses++;
      motion_in = 1'b0;
      step(H + 2);
    end
    check("sat_cnt", int'(event_count), 255);
    check("sat_pulses", pulses, 300);

    // Reset asserted between edges while in hold.
    motion_in = 1'b1;
    step(1);
    motion_in = 1'b0;
    step(4);
    #2 rst = 1'b1;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_occ", int'(occupied), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_cnt", int'(event_count), 0);
    step(2);
    rst = 1'b0;
    step(7);
    check("rewarm_ready_e7", int'(ready), 0);
    step(1);
    check("rewarm_ready_e8", int'(ready), 1);
    step(2);
    check("rewarm_occ", int'(occupied), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
